// File: rtl/pipe_debug_ctrl_if.sv
// rtl/pipe_debug_ctrl_if.sv - run-control, breakpoint config and status bundle for pipe_debug_ctrl
//
// master: debugger / pipeline side (drives requests, PC and breakpoint writes)
// slave : pipe_debug_ctrl (drives freeze and halt status)
//
// Signals:
//   brk, cont       halt / resume buttons, asynchronous to clk
//   step_req        single-cycle pulse starting a step while halted
//   step_n          instructions to step (0 behaves as 1)
//   hold_in         pipeline's own fetch stall
//   pc_if           PC presented to instruction memory
//   bp_we/bp_idx/bp_addr/bp_en  breakpoint slot write port
//   freeze          stall PC and IF/ID
//   halted, bp_hit, hit_idx, halt_pc  halt status
interface pipe_debug_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 4,
    parameter int STEP_W = 8
);
    localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    logic              brk;
    logic              cont;
    logic              step_req;
    logic [STEP_W-1:0] step_n;
    logic              hold_in;
    logic [ADDR_W-1:0] pc_if;
    logic              bp_we;
    logic [IDX_W-1:0]  bp_idx;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;
    logic              freeze;
    logic              halted;
    logic              bp_hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [ADDR_W-1:0] halt_pc;

    modport master (
        output brk, cont, step_req, step_n, hold_in, pc_if,
               bp_we, bp_idx, bp_addr, bp_en,
        input  freeze, halted, bp_hit, hit_idx, halt_pc
    );

    modport slave (
        input  brk, cont, step_req, step_n, hold_in, pc_if,
               bp_we, bp_idx, bp_addr, bp_en,
        output freeze, halted, bp_hit, hit_idx, halt_pc
    );
endinterface

// File: rtl/pipe_debug_ctrl.sv
// rtl/pipe_debug_ctrl.sv - debug / run-control unit for the 5-stage pipeline
//
// Replaces raw brk/cont with synchronised edge-detected run control,
// NUM_BP PC breakpoints and N-instruction single step. freeze is ORed
// into the PC and IF/ID stall enables by the pipeline.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   dbg     pipe_debug_ctrl_if.slave: buttons, step request, hold_in,
//           pc_if, breakpoint write port in; freeze, halted, bp_hit,
//           hit_idx, halt_pc out
module pipe_debug_ctrl #(
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_debug_ctrl_if.slave  dbg
);
    localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // Button synchronisers and edge detectors. The pulse itself is
    // registered, so a pin edge before clock k gives a pulse during k+2.
    logic [1:0] brk_sync;
    logic [1:0] cont_sync;
    logic       brk_prev;
    logic       cont_prev;
    logic       brk_e;
    logic       cont_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_sync  <= '0;
            cont_sync <= '0;
            brk_prev  <= 1'b0;
            cont_prev <= 1'b0;
            brk_e     <= 1'b0;
            cont_e    <= 1'b0;
        end else begin
            brk_sync  <= {brk_sync[0], dbg.brk};
            cont_sync <= {cont_sync[0], dbg.cont};
            brk_prev  <= brk_sync[1];
            cont_prev <= cont_sync[1];
            brk_e     <= brk_sync[1] & ~brk_prev;
            cont_e    <= cont_sync[1] & ~cont_prev;
        end
    end

    // Breakpoint slots. Comparing the write index against every slot
    // number means an index >= NUM_BP simply selects nothing.
    logic [NUM_BP-1:0] bp_en_q;
    logic [ADDR_W-1:0] bp_addr_q [NUM_BP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_en_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else if (dbg.bp_we) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (dbg.bp_idx == IDX_W'(i)) begin
                    bp_en_q[i]   <= dbg.bp_en;
                    bp_addr_q[i] <= dbg.bp_addr;
                end
            end
        end
    end

    // Scan from the top down so the lowest matching slot wins.
    logic             any_hit;
    logic [IDX_W-1:0] hit_sel;

    always_comb begin
        any_hit = 1'b0;
        hit_sel = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_addr_q[i] == dbg.pc_if)) begin
                any_hit = 1'b1;
                hit_sel = IDX_W'(i);
            end
        end
    end

    state_t            state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              skip_q, skip_d;
    logic              halted_q;
    logic              bp_hit_q, bp_hit_d;
    logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
    logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;

    logic match;
    logic freeze;
    logic adv;

    // skip masks the breakpoint at the PC we resume from, so that
    // instruction is fetched once instead of re-halting immediately.
    assign match  = any_hit & ~skip_q;
    assign freeze = (state_q == ST_HALT) | match;
    assign adv    = ~freeze & ~dbg.hold_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            skip_q    <= 1'b0;
            halted_q  <= 1'b0;
            bp_hit_q  <= 1'b0;
            hit_idx_q <= '0;
            halt_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            halted_q  <= (state_d == ST_HALT);
            bp_hit_q  <= bp_hit_d;
            hit_idx_q <= hit_idx_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        skip_d    = skip_q;
        bp_hit_d  = bp_hit_q;
        hit_idx_d = hit_idx_q;
        halt_pc_d = halt_pc_q;

        if (adv) begin
            skip_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (match) begin
                    state_d   = ST_HALT;
                    bp_hit_d  = 1'b1;
                    hit_idx_d = hit_sel;
                    halt_pc_d = dbg.pc_if;
                end else if (brk_e) begin
                    state_d   = ST_HALT;
                    bp_hit_d  = 1'b0;
                    halt_pc_d = dbg.pc_if;
                end
            end

            ST_HALT: begin
                // brk_e is deliberately ignored while halted.
                if (cont_e) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else if (dbg.step_req) begin
                    state_d = ST_STEP;
                    cnt_d   = (dbg.step_n == '0) ? STEP_W'(1) : dbg.step_n;
                    skip_d  = 1'b1;
                end
            end

            ST_STEP: begin
                if (match) begin
                    state_d   = ST_HALT;
                    bp_hit_d  = 1'b1;
                    hit_idx_d = hit_sel;
                    halt_pc_d = dbg.pc_if;
                end else if (brk_e) begin
                    state_d   = ST_HALT;
                    bp_hit_d  = 1'b0;
                    halt_pc_d = dbg.pc_if;
                end else if (cont_e) begin
                    state_d = ST_RUN;
                end else if (adv) begin
                    cnt_d = cnt_q - STEP_W'(1);
                    if (cnt_q == STEP_W'(1)) begin
                        // Last stepped instruction is being fetched now;
                        // report the PC that would come next.
                        state_d   = ST_HALT;
                        bp_hit_d  = 1'b0;
                        halt_pc_d = dbg.pc_if + ADDR_W'(4);
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign dbg.freeze  = freeze;
    assign dbg.halted  = halted_q;
    assign dbg.bp_hit  = bp_hit_q;
    assign dbg.hit_idx = hit_idx_q;
    assign dbg.halt_pc = halt_pc_q;
endmodule
